// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and register-file select codes for the regfile sequencer
package regfile_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD0     = 3'd1,
    S_RD1     = 3'd2,
    S_RSP     = 3'd3,
    S_WB_WAIT = 3'd4,
    S_WSETUP  = 3'd5,
    S_WSTROBE = 3'd6
  } regfile_seq_state_t;
  localparam logic [1:0] RF_SEL_SRC0 = 2'b00;
  localparam logic [1:0] RF_SEL_SRC1 = 2'b01;
  localparam logic [1:0] RF_SEL_SRC2 = 2'b10;
endpackage

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: operand-fetch / writeback controller for a single-port register file.
// Ports: i_req_* request from the microcode sequencer, o_rsp_* operand response,
// i_wb_* writeback data, o_rf_* / i_rf_rdata register file pins (strobes active-low).
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 5,
  parameter int ZERO_REG = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [DEPTH-1:0] i_req_src0,
  input  logic [DEPTH-1:0] i_req_src1,
  input  logic [DEPTH-1:0] i_req_dst,
  input  logic             i_req_rd0,
  input  logic             i_req_rd1,
  input  logic             i_req_wb,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_op0,
  output logic [WIDTH-1:0] o_rsp_op1,
  input  logic             i_wb_valid,
  output logic             o_wb_ready,
  input  logic [WIDTH-1:0] i_wb_data,
  output logic [1:0]       o_rf_sel,
  output logic [DEPTH-1:0] o_rf_src0,
  output logic [DEPTH-1:0] o_rf_src1,
  output logic [DEPTH-1:0] o_rf_src2,
  output logic             o_rf_n_oe,
  output logic             o_rf_n_we,
  output logic [WIDTH-1:0] o_rf_wdata,
  input  logic [WIDTH-1:0] i_rf_rdata
);
  regfile_seq_state_t r_state, w_next;
  logic             r_rd1, r_wb, r_n_oe, r_n_we;
  logic [1:0]       r_sel;
  logic [DEPTH-1:0] r_src0, r_src1, r_src2;
  logic [WIDTH-1:0] r_op0, r_op1, r_wdata;
  logic             w_req_hs, w_rsp_hs, w_wb_hs, w_drop_wb;
  assign o_req_ready = r_state == S_IDLE;
  assign o_rsp_valid = r_state == S_RSP;
  assign o_wb_ready  = r_state == S_WB_WAIT;
  assign w_req_hs    = i_req_valid && o_req_ready;
  assign w_rsp_hs    = o_rsp_valid && i_rsp_ready;
  assign w_wb_hs     = i_wb_valid && o_wb_ready;
  assign w_drop_wb   = (ZERO_REG != 0) && (r_src2 == '0);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_req_hs) w_next = i_req_rd0 ? S_RD0 : i_req_rd1 ? S_RD1 : S_RSP;
      S_RD0:     w_next = r_rd1 ? S_RD1 : S_RSP;
      S_RD1:     w_next = S_RSP;
      S_RSP:     if (w_rsp_hs) w_next = r_wb ? S_WB_WAIT : S_IDLE;
      S_WB_WAIT: if (w_wb_hs) w_next = w_drop_wb ? S_IDLE : S_WSETUP;
      S_WSETUP:  w_next = S_WSTROBE;
      S_WSTROBE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end
  // Strobes and select are registered from the next-state decode so the pins never glitch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_n_oe  <= 1'b1;
      r_n_we  <= 1'b1;
      r_sel   <= RF_SEL_SRC0;
      r_rd1   <= 1'b0;
      r_wb    <= 1'b0;
      r_src0  <= '0;
      r_src1  <= '0;
      r_src2  <= '0;
      r_op0   <= '0;
      r_op1   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_n_oe  <= !(w_next == S_RD0 || w_next == S_RD1);
      r_n_we  <= w_next != S_WSTROBE;
      r_sel   <= w_next == S_RD0 ? RF_SEL_SRC0 :
                 w_next == S_RD1 ? RF_SEL_SRC1 :
                 (w_next == S_WSETUP || w_next == S_WSTROBE) ? RF_SEL_SRC2 : r_sel;
      if (w_req_hs) begin
        r_src0 <= i_req_src0;
        r_src1 <= i_req_src1;
        r_src2 <= i_req_dst;
        r_rd1  <= i_req_rd1;
        r_wb   <= i_req_wb;
        r_op0  <= '0;
        r_op1  <= '0;
      end
      if (r_state == S_RD0) r_op0 <= (ZERO_REG != 0 && r_src0 == '0) ? '0 : i_rf_rdata;
      if (r_state == S_RD1) r_op1 <= (ZERO_REG != 0 && r_src1 == '0) ? '0 : i_rf_rdata;
      if (w_wb_hs) r_wdata <= i_wb_data;
    end
  end
  assign o_rf_sel   = r_sel;
  assign o_rf_n_oe  = r_n_oe;
  assign o_rf_n_we  = r_n_we;
  assign o_rf_src0  = r_src0;
  assign o_rf_src1  = r_src1;
  assign o_rf_src2  = r_src2;
  assign o_rf_wdata = r_wdata;
  assign o_rsp_op0  = r_op0;
  assign o_rsp_op1  = r_op1;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: randomized self-checking bench with a register file model and a transaction-level reference
module tb_regfile_sequencer;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_rd0 = 0, req_rd1 = 0, req_wb = 0;
  logic [4:0]  req_src0 = 0, req_src1 = 0, req_dst = 0;
  logic        rsp_ready = 0, wb_valid = 0;
  logic [31:0] wb_data = 0;
  logic        req_ready, rsp_valid, wb_ready, rf_n_oe, rf_n_we;
  logic [31:0] rsp_op0, rsp_op1, rf_wdata, rf_rdata;
  logic [1:0]  rf_sel;
  logic [4:0]  rf_src0, rf_src1, rf_src2;
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic [31:0] junk = 0;
  int          vec = 0, miss = 0;
  bit          mon_en = 0;
  logic        prev_we = 1;
  logic [4:0]  prev_src2 = 0;
  logic [31:0] prev_wdata = 0;
  always #5 clk = ~clk;
  regfile_sequencer #(.WIDTH(32), .DEPTH(5), .ZERO_REG(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_src0(req_src0), .i_req_src1(req_src1), .i_req_dst(req_dst),
    .i_req_rd0(req_rd0), .i_req_rd1(req_rd1), .i_req_wb(req_wb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_op0(rsp_op0), .o_rsp_op1(rsp_op1),
    .i_wb_valid(wb_valid), .o_wb_ready(wb_ready), .i_wb_data(wb_data),
    .o_rf_sel(rf_sel), .o_rf_src0(rf_src0), .o_rf_src1(rf_src1), .o_rf_src2(rf_src2),
    .o_rf_n_oe(rf_n_oe), .o_rf_n_we(rf_n_we), .o_rf_wdata(rf_wdata), .i_rf_rdata(rf_rdata)
  );
  // Register file model: garbage on the bus unless output-enabled, write on a clock edge with strobe low.
  assign rf_rdata = !rf_n_oe ? mem[rf_sel == 2'b01 ? rf_src1 : rf_src0] : junk;
  always @(posedge clk) begin
    junk <= $urandom;
    if (!rf_n_we) mem[rf_src2] <= rf_wdata;
  end
  always @(negedge clk) if (mon_en) begin
    vec++;
    if (!(rf_n_oe | rf_n_we) || rf_sel == 2'b11) begin
      miss++;
      $display("FAIL contract: n_oe=%b n_we=%b sel=%b", rf_n_oe, rf_n_we, rf_sel);
    end
    if (!prev_we && (rf_src2 !== prev_src2 || rf_wdata !== prev_wdata)) begin
      miss++;
      $display("FAIL wb_hold: src2=%0d/%0d wdata=%h/%h", rf_src2, prev_src2, rf_wdata, prev_wdata);
    end
    prev_we = rf_n_we;
    prev_src2 = rf_src2;
    prev_wdata = rf_wdata;
  end
  task automatic run_txn(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] d,
                         input logic e0, input logic e1, input logic ew,
                         input logic [31:0] wd, input int stall, input int wdly);
    logic [31:0] x0, x1;
    logic [1:0]  xs;
    int n;
    x0 = (e0 && s0 != 0) ? ref_mem[s0] : 32'h0;
    x1 = (e1 && s1 != 0) ? ref_mem[s1] : 32'h0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    vec++;
    if (req_ready !== 1'b1) begin miss++; $display("FAIL req_ready_wait: got %b want 1", req_ready); end
    req_src0 = s0; req_src1 = s1; req_dst = d;
    req_rd0 = e0; req_rd1 = e1; req_wb = ew; req_valid = 1; rsp_ready = 0;
    @(negedge clk);
    req_valid = 0;
    n = 1;
    while (!rsp_valid && n < 10) begin
      xs = (e0 && n == 1) ? 2'b00 : 2'b01;
      vec++;
      if (rf_n_oe !== 1'b0 || rf_sel !== xs) begin
        miss++;
        $display("FAIL read_strobe: n_oe=%b sel=%b want 0/%b", rf_n_oe, rf_sel, xs);
      end
      @(negedge clk);
      n++;
    end
    vec++;
    if (n != 1 + int'(e0) + int'(e1)) begin
      miss++;
      $display("FAIL rsp_latency: got %0d want %0d", n, 1 + int'(e0) + int'(e1));
    end
    for (int i = 0; i <= stall; i++) begin
      vec++;
      if (rsp_valid !== 1'b1 || rsp_op0 !== x0 || rsp_op1 !== x1) begin
        miss++;
        $display("FAIL operands: valid=%b op0=%h op1=%h want 1 %h %h", rsp_valid, rsp_op0, rsp_op1, x0, x1);
      end
      if (i == stall) rsp_ready = 1;
      @(negedge clk);
    end
    rsp_ready = 0;
    vec++;
    if (!ew) begin
      if (req_ready !== 1'b1) begin miss++; $display("FAIL rsp_to_idle: req_ready=%b want 1", req_ready); end
      return;
    end
    if (wb_ready !== 1'b1) begin miss++; $display("FAIL wb_ready: got %b want 1", wb_ready); end
    repeat (wdly) @(negedge clk);
    wb_data = wd; wb_valid = 1;
    @(negedge clk);
    wb_valid = 0;
    if (d == 0) begin
      vec++;
      if (req_ready !== 1'b1 || rf_n_we !== 1'b1) begin
        miss++;
        $display("FAIL wb_drop: req_ready=%b n_we=%b want 1 1", req_ready, rf_n_we);
      end
      return;
    end
    vec++;
    if (rf_n_we !== 1'b1 || rf_n_oe !== 1'b1 || rf_sel !== 2'b10) begin
      miss++;
      $display("FAIL wsetup: n_we=%b n_oe=%b sel=%b want 1 1 10", rf_n_we, rf_n_oe, rf_sel);
    end
    @(negedge clk);
    vec++;
    if (rf_n_we !== 1'b0 || rf_sel !== 2'b10 || rf_src2 !== d || rf_wdata !== wd) begin
      miss++;
      $display("FAIL wstrobe: n_we=%b sel=%b dst=%0d data=%h want 0 10 %0d %h", rf_n_we, rf_sel, rf_src2, rf_wdata, d, wd);
    end
    ref_mem[d] = wd;
    @(negedge clk);
    vec++;
    if (req_ready !== 1'b1 || rf_n_we !== 1'b1) begin
      miss++;
      $display("FAIL wb_done: req_ready=%b n_we=%b want 1 1", req_ready, rf_n_we);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    @(negedge clk);
    vec++;
    if (req_ready !== 1 || rsp_valid !== 0 || wb_ready !== 0) begin
      miss++;
      $display("FAIL reset_hs: req_ready=%b rsp_valid=%b wb_ready=%b want 1 0 0", req_ready, rsp_valid, wb_ready);
    end
    vec++;
    if (rf_n_oe !== 1 || rf_n_we !== 1 || rf_sel !== 2'b00) begin
      miss++;
      $display("FAIL reset_strobes: n_oe=%b n_we=%b sel=%b want 1 1 00", rf_n_oe, rf_n_we, rf_sel);
    end
    vec++;
    if (rf_src0 !== 0 || rf_src1 !== 0 || rf_src2 !== 0 || rf_wdata !== 0 || rsp_op0 !== 0 || rsp_op1 !== 0) begin
      miss++;
      $display("FAIL reset_regs: src=%0d/%0d/%0d wdata=%h ops=%h/%h want all 0", rf_src0, rf_src1, rf_src2, rf_wdata, rsp_op0, rsp_op1);
    end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_reads;
    mem[3] = 32'hDEADBEEF; ref_mem[3] = 32'hDEADBEEF;
    mem[7] = 32'h12345678; ref_mem[7] = 32'h12345678;
    run_txn(5'd3, 5'd7, 5'd0, 1, 1, 0, 0, 0, 0);
    run_txn(5'd0, 5'd7, 5'd0, 0, 1, 0, 0, 5, 0);
    run_txn(5'd3, 5'd7, 5'd0, 0, 0, 0, 0, 1, 0);
  endtask
  task automatic test_writeback;
    run_txn(5'd0, 5'd0, 5'd9, 0, 0, 1, 32'hCAFEF00D, 0, 2);
    run_txn(5'd9, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic test_zero_reg;
    mem[0] = 32'h5555AAAA; ref_mem[0] = 32'h5555AAAA;
    run_txn(5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0);
    run_txn(5'd0, 5'd0, 5'd0, 0, 0, 1, 32'h77777777, 0, 0);
  endtask
  task automatic test_reset_wstrobe;
    req_src0 = 0; req_src1 = 0; req_dst = 5'd9;
    req_rd0 = 0; req_rd1 = 0; req_wb = 1; req_valid = 1;
    @(negedge clk);
    req_valid = 0; rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0; wb_data = 32'h0BADF00D; wb_valid = 1;
    @(negedge clk);
    wb_valid = 0;
    @(negedge clk);
    vec++;
    if (rf_n_we !== 1'b0) begin miss++; $display("FAIL rst_pre_strobe: n_we=%b want 0", rf_n_we); end
    #1 rst = 1;
    #1;
    vec++;
    if (rf_n_we !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miss++;
      $display("FAIL rst_async: n_we=%b req_ready=%b rsp_valid=%b want 1 1 0", rf_n_we, req_ready, rsp_valid);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run_txn(5'd9, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic test_back_to_back;
    mon_en = 1;
    for (int t = 0; t < 60; t++)
      run_txn(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              1'($urandom), 1'($urandom), 1'($urandom), $urandom,
              $urandom_range(0, 2), $urandom_range(0, 2));
    mon_en = 0;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset;
    test_reads;
    test_writeback;
    test_zero_reg;
    test_reset_wstrobe;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
